// File: rtl/core_pkg.sv
// Shared definitions for the core instruction word: field positions, the
// idle word, sequencer state encoding and dataflow mode encodings.
package core_pkg;

  // Instruction word width and the address width its fields are laid out for.
  localparam int INST_W = 47;
  localparam int ADDR_W = 11;

  // Single-bit control fields.
  localparam int LOAD_BIT     = 0;
  localparam int EXEC_BIT     = 1;
  localparam int L0_WR_BIT    = 2;
  localparam int L0_RD_BIT    = 3;
  localparam int IFIFO_WR_BIT = 4;
  localparam int IFIFO_RD_BIT = 5;
  localparam int OFIFO_RD_BIT = 6;

  // Activation/weight SRAM (xmem) fields; enables are active-low.
  localparam int XMEM_ADDR_LSB = 7;
  localparam int WEN_XMEM_BIT  = 18;
  localparam int CEN_XMEM_BIT  = 19;

  // Partial-sum SRAM (pmem) fields; enables are active-low.
  localparam int PMEM_RD_ADDR_LSB = 20;
  localparam int PMEM_WR_ADDR_LSB = 31;
  localparam int WEN_PMEM_BIT     = 42;
  localparam int REN_PMEM_BIT     = 43;
  localparam int CEN_PMEM_BIT     = 44;

  localparam int ACC_BIT  = 45;
  localparam int MODE_BIT = 46;

  // Dataflow mode carried in the MODE bit.
  localparam logic MODE_WS = 1'b0;  // weight stationary
  localparam logic MODE_OS = 1'b1;  // output stationary

  // Idle word: every active-low enable deasserted, every other bit clear.
  localparam logic [INST_W-1:0] IDLE_WORD =
      (INST_W'(1) << CEN_XMEM_BIT) |
      (INST_W'(1) << WEN_XMEM_BIT) |
      (INST_W'(1) << CEN_PMEM_BIT) |
      (INST_W'(1) << REN_PMEM_BIT) |
      (INST_W'(1) << WEN_PMEM_BIT);

  // Tile sequencer states, in the order a tile walks through them.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_RD,
    ST_W_LD,
    ST_W_GAP,
    ST_A_RD,
    ST_EXEC,
    ST_WAIT,
    ST_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/core_sequencer.sv
// Tile instruction sequencer for core: loads weights into the PE array via
// L0, streams activations through execute, then drains the OFIFO into pmem.
// Every output is a flop; the instruction word lags the FSM state by one cycle.
module core_sequencer
  import core_pkg::*;
#(
  parameter int row     = 8,   // weight words per tile
  parameter int col     = 8,   // weight load / settle cycles
  parameter int addr_bw = 11   // SRAM address width; the inst field map assumes 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic [addr_bw-1:0] num_act,
  input  logic               acc_en,
  input  logic               ofifo_valid,
  output logic [INST_W-1:0]  inst,
  output logic               busy,
  output logic               done
);

  localparam logic [addr_bw-1:0] ROW_LAST = addr_bw'(row - 1);
  localparam logic [addr_bw-1:0] COL_LAST = addr_bw'(col - 1);
  localparam logic [addr_bw-1:0] CNT_ONE  = addr_bw'(1);

  state_t             state;
  logic [addr_bw-1:0] cnt;         // shared phase offset; write index during WB
  logic [addr_bw-1:0] w_base_q;
  logic [addr_bw-1:0] a_base_q;
  logic [addr_bw-1:0] p_base_q;
  logic [addr_bw-1:0] num_act_q;
  logic               acc_q;
  logic               wr_pend;     // an ofifo_rd went out last cycle; write it now

  logic [addr_bw:0]   issued;
  logic               rd_fire;
  logic               wr_fire;
  logic               last_wr;
  logic               xmem_rd_prev;

  // WB bookkeeping and the read-valid source for l0_wr.
  // NOTE: every signal gets a value on every path through this block, so no
  // latch can be inferred; keep it that way when adding terms.
  always_comb begin
    // Reads already handed to the write pipeline: completed writes plus the
    // one in flight.
    issued       = {1'b0, cnt} + {{addr_bw{1'b0}}, wr_pend};
    rd_fire      = (state == ST_WB) && ofifo_valid && (issued < {1'b0, num_act_q});
    wr_fire      = (state == ST_WB) && wr_pend;
    last_wr      = wr_fire && (cnt == num_act_q - CNT_ONE);
    // The word currently on inst is an xmem read; its data lands in L0 next cycle.
    xmem_rd_prev = ~inst[CEN_XMEM_BIT] & inst[WEN_XMEM_BIT];
  end

  // Tile FSM with registered instruction word, busy and done.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values; later assignments to an inst bit in the same
  // edge simply override the idle default set at the top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      w_base_q  <= '0;
      a_base_q  <= '0;
      p_base_q  <= '0;
      num_act_q <= '0;
      acc_q     <= 1'b0;
      wr_pend   <= 1'b0;
      inst      <= IDLE_WORD;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy    <= (state != ST_IDLE);
      done    <= (state == ST_DONE);
      wr_pend <= rd_fire;

      inst              <= IDLE_WORD;
      inst[MODE_BIT]    <= MODE_WS;
      inst[L0_WR_BIT]   <= xmem_rd_prev;

      case (state)
        ST_IDLE: begin
          if (start) begin
            w_base_q  <= w_base;
            a_base_q  <= a_base;
            p_base_q  <= p_base;
            num_act_q <= num_act;
            acc_q     <= acc_en;
            cnt       <= '0;
            state     <= ST_W_RD;
          end
        end

        ST_W_RD: begin
          inst[CEN_XMEM_BIT]                   <= 1'b0;
          inst[XMEM_ADDR_LSB +: addr_bw]       <= w_base_q + cnt;
          if (cnt == ROW_LAST) begin
            cnt   <= '0;
            state <= ST_W_LD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_W_LD: begin
          inst[LOAD_BIT]  <= 1'b1;
          inst[L0_RD_BIT] <= 1'b1;
          if (cnt == COL_LAST) begin
            cnt   <= '0;
            state <= ST_W_GAP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_W_GAP: begin
          // Idle word while loaded weights settle; an empty tile ends here.
          if (cnt == COL_LAST) begin
            cnt   <= '0;
            state <= (num_act_q == '0) ? ST_DONE : ST_A_RD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_A_RD: begin
          inst[CEN_XMEM_BIT]             <= 1'b0;
          inst[XMEM_ADDR_LSB +: addr_bw] <= a_base_q + cnt;
          if (cnt == num_act_q - CNT_ONE) begin
            cnt   <= '0;
            state <= ST_EXEC;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_EXEC: begin
          inst[EXEC_BIT]  <= 1'b1;
          inst[L0_RD_BIT] <= 1'b1;
          if (cnt == num_act_q - CNT_ONE) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_WAIT: begin
          if (ofifo_valid) state <= ST_WB;
        end

        ST_WB: begin
          if (rd_fire) inst[OFIFO_RD_BIT] <= 1'b1;
          if (wr_fire) begin
            inst[CEN_PMEM_BIT]                <= 1'b0;
            inst[WEN_PMEM_BIT]                <= 1'b0;
            inst[PMEM_WR_ADDR_LSB +: addr_bw] <= p_base_q + cnt;
            inst[PMEM_RD_ADDR_LSB +: addr_bw] <= p_base_q + cnt;
            inst[ACC_BIT]                     <= acc_q;
            if (last_wr) begin
              cnt   <= '0;
              state <= ST_DONE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. Each tile's expected behaviour is
// derived from its inputs: ordered xmem read addresses, pulse counts, ordered
// pmem writes, done latency and the idle word at the end.
`timescale 1ns/1ps
module tb_core_sequencer;
  import core_pkg::*;

  localparam int ROW    = 8;
  localparam int COL    = 8;
  localparam int AW     = 11;
  localparam int BUDGET = 800;

  // Instruction field positions as documented for the core.
  localparam int B_LOAD = 0,  B_EXEC = 1,  B_L0WR = 2,  B_L0RD = 3;
  localparam int B_IFWR = 4,  B_IFRD = 5,  B_OFRD = 6,  B_XADDR = 7;
  localparam int B_WENX = 18, B_CENX = 19, B_PRD = 20,  B_PWR = 31;
  localparam int B_WENP = 42, B_RENP = 43, B_CENP = 44, B_ACC = 45, B_MODE = 46;
  // Bits 19, 18, 44, 43, 42 set; everything else clear.
  localparam logic [46:0] TB_IDLE = 47'h1C00_000C_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AW-1:0]     w_base, a_base, p_base, num_act;
  logic              acc_en;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;

  int passed = 0;
  int total  = 0;

  core_sequencer #(.row(ROW), .col(COL), .addr_bw(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .w_base      (w_base),
    .a_base      (a_base),
    .p_base      (p_base),
    .num_act     (num_act),
    .acc_en      (acc_en),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Index of the first difference between two address lists, -1 if identical.
  function automatic int first_diff(input logic [AW-1:0] a[$], input logic [AW-1:0] b[$]);
    int lim;
    lim = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < lim; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return lim;
    return -1;
  endfunction

  // Runs one tile from a negedge; ends at the negedge one sample after done.
  // vmode: 0 = ofifo_valid always high, 1 = random, 2 = pattern 1,0,0,...
  task automatic run_tile(input string name, input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                          input logic [AW-1:0] pb, input logic [AW-1:0] na,
                          input logic acc, input int vmode);
    logic [AW-1:0] exp_x[$], got_x[$], exp_w[$], got_w[$];
    int n, exp_lat, cyc, done_at, bad, gv, ev;
    int n_l0wr, n_load, n_exec, n_ofrd, n_done, proto_err, busy_err;
    logic prev_rd;
    bit finished;

    n = int'(na);
    for (int k = 0; k < ROW; k++) exp_x.push_back(AW'(int'(wb) + k));
    for (int k = 0; k < n; k++) begin
      exp_x.push_back(AW'(int'(ab) + k));
      exp_w.push_back(AW'(int'(pb) + k));
    end
    exp_lat = (n == 0) ? 1 + ROW + 2*COL : 1 + ROW + 2*COL + 2*n + 1 + n + 1;

    n_l0wr = 0; n_load = 0; n_exec = 0; n_ofrd = 0; n_done = 0;
    proto_err = 0; busy_err = 0; prev_rd = 1'b0; done_at = -1; finished = 0;

    w_base = wb; a_base = ab; p_base = pb; num_act = na; acc_en = acc;
    ofifo_valid = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (!finished && cyc <= BUDGET) begin
      @(negedge clk);
      if (!inst[B_CENX]) begin
        got_x.push_back(inst[B_XADDR +: AW]);
        if (!inst[B_WENX]) proto_err++;
      end
      if (inst[B_L0WR]) n_l0wr++;
      if (inst[B_LOAD]) n_load++;
      if (inst[B_EXEC]) n_exec++;
      if (inst[B_OFRD]) n_ofrd++;
      if (!inst[B_CENP]) begin
        got_w.push_back(inst[B_PWR +: AW]);
        if (inst[B_WENP] || !inst[B_RENP] || !prev_rd ||
            inst[B_PRD +: AW] !== inst[B_PWR +: AW] || inst[B_ACC] !== acc) proto_err++;
      end else if (inst[B_ACC] || !inst[B_WENP]) begin
        proto_err++;
      end
      prev_rd = inst[B_OFRD];
      if (inst[B_MODE] || inst[B_IFWR] || inst[B_IFRD]) proto_err++;
      if (cyc == 0) begin
        if (busy !== 1'b0 || inst !== TB_IDLE) busy_err++;
      end else if (done_at < 0 && busy !== 1'b1) begin
        busy_err++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && cyc == done_at + 1) finished = 1;

      // Next-cycle stimulus: start noise while busy, scrambled inputs.
      start   = (cyc < ROW - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      w_base  = AW'($urandom);
      a_base  = AW'($urandom);
      p_base  = AW'($urandom);
      num_act = AW'($urandom);
      acc_en  = 1'($urandom_range(0, 1));
      case (vmode)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = 1'($urandom_range(0, 1));
        default: ofifo_valid = ((cyc % 3) == 0);
      endcase
      cyc++;
    end
    start = 1'b0;

    total++;
    if (!finished) begin
      $display("FAIL %s timeout: no done within %0d cycles", name, BUDGET);
      return;
    end else passed++;

    total++;
    bad = first_diff(got_x, exp_x);
    if (bad >= 0) begin
      gv = (bad < got_x.size()) ? int'(got_x[bad]) : -1;
      ev = (bad < exp_x.size()) ? int'(exp_x[bad]) : -1;
      $display("FAIL %s xmem_addr: read %0d got %0d (%0d reads) expected %0d (%0d reads)",
               name, bad, gv, got_x.size(), ev, exp_x.size());
    end else passed++;

    total++;
    bad = first_diff(got_w, exp_w);
    if (bad >= 0) begin
      gv = (bad < got_w.size()) ? int'(got_w[bad]) : -1;
      ev = (bad < exp_w.size()) ? int'(exp_w[bad]) : -1;
      $display("FAIL %s pmem_wr_addr: write %0d got %0d (%0d writes) expected %0d (%0d writes)",
               name, bad, gv, got_w.size(), ev, exp_w.size());
    end else passed++;

    total++;
    if (n_l0wr !== ROW + n) $display("FAIL %s l0_wr_count: got %0d expected %0d", name, n_l0wr, ROW + n);
    else passed++;

    total++;
    if (n_load !== COL) $display("FAIL %s load_count: got %0d expected %0d", name, n_load, COL);
    else passed++;

    total++;
    if (n_exec !== n) $display("FAIL %s exec_count: got %0d expected %0d", name, n_exec, n);
    else passed++;

    total++;
    if (n_ofrd !== n) $display("FAIL %s ofifo_rd_count: got %0d expected %0d", name, n_ofrd, n);
    else passed++;

    total++;
    if (n_done !== 1) $display("FAIL %s done_pulses: got %0d expected 1", name, n_done);
    else passed++;

    if (vmode == 0) begin
      total++;
      if (done_at !== exp_lat) $display("FAIL %s done_latency: got %0d expected %0d", name, done_at, exp_lat);
      else passed++;
    end

    total++;
    if (proto_err !== 0) $display("FAIL %s field_protocol: got %0d bad words expected 0", name, proto_err);
    else passed++;

    total++;
    if (busy_err !== 0) $display("FAIL %s busy_window: got %0d bad cycles expected 0", name, busy_err);
    else passed++;

    total++;
    if (inst !== TB_IDLE || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s end_idle: got inst=%h busy=%b done=%b expected inst=%h busy=0 done=0",
               name, inst, busy, done, TB_IDLE);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0; acc_en = 1'b0;
    w_base = '0; a_base = '0; p_base = '0; num_act = '0;
    repeat (3) @(negedge clk);
    total++;
    if (inst !== TB_IDLE || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_hold: got inst=%h busy=%b done=%b expected inst=%h busy=0 done=0",
               inst, busy, done, TB_IDLE);
    else passed++;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (inst !== TB_IDLE || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL reset_release cycle %0d: got inst=%h busy=%b done=%b expected inst=%h busy=0 done=0",
                 i, inst, busy, done, TB_IDLE);
      else passed++;
    end
  endtask

  task automatic test_basic();
    run_tile("basic", 11'd0, 11'd16, 11'd0, 11'd4, 1'b0, 0);
  endtask

  task automatic test_zero_vectors();
    run_tile("zero_act", 11'd100, 11'd200, 11'd300, 11'd0, 1'b1, 0);
  endtask

  task automatic test_wrap();
    run_tile("wrap", 11'd2040, 11'd2046, 11'd2045, 11'd3, 1'b1, 0);
  endtask

  task automatic test_stall();
    run_tile("stall", 11'd5, 11'd40, 11'd60, 11'd4, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    run_tile("b2b_first", 11'd7, 11'd300, 11'd900, 11'd2, 1'b1, 0);
    run_tile("b2b_second", 11'd2000, 11'd10, 11'd2047, 11'd5, 1'b0, 0);
  endtask

  task automatic test_reset_mid_exec();
    w_base = 11'd0; a_base = 11'd50; p_base = 11'd70; num_act = 11'd6;
    acc_en = 1'b0; ofifo_valid = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    total++;
    if (inst[B_EXEC] !== 1'b1) $display("FAIL mid_exec_reached: got execute=%b expected 1", inst[B_EXEC]);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if (inst !== TB_IDLE || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL async_reset: got inst=%h busy=%b done=%b expected inst=%h busy=0 done=0",
               inst, busy, done, TB_IDLE);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (inst !== TB_IDLE || busy !== 1'b0)
      $display("FAIL post_reset_idle: got inst=%h busy=%b expected inst=%h busy=0", inst, busy, TB_IDLE);
    else passed++;
    run_tile("after_reset", 11'd1000, 11'd1500, 11'd2000, 11'd5, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      run_tile($sformatf("random%0d", it), AW'($urandom), AW'($urandom), AW'($urandom),
               AW'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_vectors();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Instruction sequencer that sits directly upstream of `core` and drives its 47-bit `inst` bus for one complete tile:

- load weights from xmem into the PE array through L0;
- stream activations and execute;
- drain the OFIFO into pmem.

Software supplies base addresses and a vector count, pulses `start`, and waits for `done`. This replaces hand-written testbench instruction streams.

## Interface
Parameters:
- `row`, 8, PE array rows (weight words per tile).
- `col`, 8, PE array columns (load cycles).
- `addr_bw`, 11, SRAM address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `w_base`  in  addr_bw  xmem address of first weight word.
- `a_base`  in  addr_bw  xmem address of first activation word.
- `p_base`  in  addr_bw  pmem address of first output word.
- `num_act`  in  addr_bw  activation vectors per tile (0 allowed).
- `acc_en`  in  1  accumulate mode; drives `inst[45]` during WB.
- `ofifo_valid`  in  1  from `core`.
- `inst`  out  47  registered instruction word to `core`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of tile.

## Operation
`inst` field map is fixed:
- [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [4] ififo_wr, [5] ififo_rd, [6] ofifo_rd.
- [17:7] xmem_addr, [18] WEN_xmem, [19] CEN_xmem.
- [30:20] pmem_rd_addr, [41:31] pmem_wr_addr.
- [42] WEN_pmem, [43] REN_pmem, [44] CEN_pmem.
- [45] acc, [46] mode (0 = weight stationary).

Idle word: CEN/WEN/REN bits = 1 (active-low, inactive), every other bit 0.

FSM states: IDLE → W_RD → W_LD → W_GAP → A_RD → EXEC → WAIT → WB → DONE → IDLE.
- IDLE: idle word. `start`=1 latches all inputs, then → W_RD.
- W_RD, `row` cycles, k=0..row-1: CEN_xmem=0, WEN_xmem=1, xmem_addr=w_base+k.
- W_LD, `col` cycles: load=1, l0_rd=1.
- W_GAP, `col` cycles: idle word (weight settle).
- Zero-vector skip: if latched num_act=0, W_GAP → DONE.
- A_RD, num_act cycles: xmem read at a_base+k.
- EXEC, num_act cycles: execute=1, l0_rd=1.
- WAIT: idle word until `ofifo_valid`=1.
- WB: counts k=0..num_act-1.
  - ofifo_rd=1 in each cycle where `ofifo_valid`=1 and reads remain.
  - One cycle after each ofifo_rd: CEN_pmem=0, WEN_pmem=0, pmem_wr_addr=p_base+k, pmem_rd_addr=same, acc=latched acc_en.
  - Leave WB after the num_act-th write.
- DONE: one cycle, done=1, then → IDLE.

l0_wr is a read-valid flop: it asserts one cycle after every xmem read, regardless of state. It therefore spills one cycle into W_LD and EXEC.

Arithmetic and boundary rules:
- All addresses are base+offset, truncated mod 2^addr_bw (wrap at 2047→0).
- `start` while busy is ignored. Inputs changing after the start cycle are ignored.
- `ofifo_valid` low mid-WB stalls ofifo_rd and the pmem write; the counter holds.

## Timing
- All outputs registered.
- Reset (async assert): state=IDLE, inst=idle word, busy=0, done=0, counters=0. Applies identically mid-operation; release resumes in IDLE.
- `start` at edge t: busy=1 and the first W_RD word both appear after edge t+1.
- Cycles from start to DONE when ofifo_valid is immediately ready: 1 + row + 2·col + 2·num_act + WAIT + num_act + 1, where the final +1 is the write pipeline tail.
- `done` asserts for exactly one cycle. busy drops in the same cycle done deasserts.

## Structure
- Shared package `core_pkg`:
  - inst field bit-position localparams;
  - idle-word constant;
  - FSM state enum;
  - mode encodings.

  `core` and the testbench import the same package.
- Single module, no sub-modules. Datapath is one shared offset counter, the l0_wr read-valid flop, and the WB write-pipeline flop.

## Test plan
- Reset held low, then released with no start → inst = idle word (bits 19,18,44,43,42 = 1, all others 0), busy=0.
- w_base=0, a_base=16, p_base=0, num_act=4, ofifo_valid tied 1:
  - xmem_addr 0..7 then 16..19;
  - l0_wr pulses = 12;
  - 4 pmem writes at addresses 0..3;
  - done exactly once, 1+8+16+8+1+4+1 cycles after start (WAIT lasts 1 cycle since ofifo_valid is already high).
- num_act=0 → 8 weight reads, no EXEC/WB activity, done after W_GAP.
- a_base=2046, num_act=3 → xmem addresses 2046, 2047, 0.
- ofifo_valid toggles 1,0,0,1,… in WB with num_act=4 → exactly 4 ofifo_rd and 4 writes, addresses contiguous, no duplicates.
- Reset asserted mid-EXEC → inst returns to idle word asynchronously. A second start after release completes normally with acc=acc_en on the writes.
